instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch and next-PC stage of the MIPS core. It holds the program counter, fetches instructions from a handshaked instruction memory, and presents each instruction word on `code` for one execute cycle to the main decoder/controller. In that execute cycle it takes the decoder's branch and jump controls back, computes the next PC (sequential, beq, j/jal, jr), and provides the jal link value.

## Interface

- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `im_req` output 1: instruction memory request; held high until `im_ack`.
- `im_addr` output 32: fetch address; equals `pc` while `im_req` is high.
- `im_ack` input 1: memory has returned `im_rdata` this cycle.
- `im_rdata` input 32: instruction word; sampled only when `im_req && im_ack`.
- `code` output 32: registered instruction word for the decoder.
- `code_valid` output 1: high for exactly the one EXEC cycle of each instruction; qualifies GPRWr/DMWr downstream.
- `pc` output 32: address of the instruction in `code`.
- `pc_plus4` output 32: `pc + 4`; the jal link value.
- `Zero` input 1: ALU zero flag.
- `npc_sel` input 1: beq in decode.
- `jsome` input 1: j/jal in decode.
- `jr` input 1: jr in decode.
- `jr_target` input 32: GPR[rs] read data.
- `addr_err` output 1: sticky; a misaligned jr target was taken.
- `instret` output 32: count of instructions retired.

## Operation

- States: IDLE, FETCH, EXEC, HALT.
- IDLE is the reset state. It always moves to FETCH on the next edge.
- FETCH: `im_req`=1 and `im_addr`=`pc`.
  - On `im_ack`, `code` <= `im_rdata` and the state moves to EXEC.
  - Otherwise the state stays in FETCH with `im_addr` stable.
- EXEC: `code_valid`=1 and `im_req`=0. Control inputs are sampled only here.
- Next-PC priority, evaluated in EXEC:
  1. `jr`: `jr_target`.
  2. `jsome`: {`pc_plus4`[31:28], `code`[25:0], 2'b00}.
  3. `npc_sel && Zero`: `pc_plus4` + ({{14{`code`[15]}}, `code`[15:0], 2'b00}).
  4. Otherwise: `pc_plus4`.
- All next-PC arithmetic is 32-bit and wraps modulo 2^32. No overflow flag.
- EXEC exit, normal case: `pc` <= next PC, `instret` <= `instret`+1 (wraps at 2^32), state moves to FETCH.
- EXEC exit, when `jr` is taken and `jr_target`[1:0] != 0:
  - `pc` is unchanged.
  - `addr_err` <= 1.
  - `instret` is still incremented, because the jr retired.
  - State moves to HALT.
- HALT: `im_req`=0 and `code_valid`=0. The block stays there until `rst`. `code` and `pc` hold their values.
- Simultaneous `jr` and `jsome` (illegal decode): `jr` wins, per the priority above.
- `npc_sel` with `Zero`=0: sequential next PC.
- `im_ack` while `im_req`=0 is ignored.
- `pc_plus4` is combinational from `pc` at all times.

## Timing

- Reset values, applied asynchronously:
  - state=IDLE, `pc`=`RESET_PC`, `code`=0, `code_valid`=0, `im_req`=0, `addr_err`=0, `instret`=0.
- Reset asserted mid-FETCH: `im_req` falls in the same cycle (it is a decode of state). A pending or simultaneous `im_ack` is discarded.
- First `im_req` is the cycle after reset is released (IDLE occupies one cycle).
- Minimum latency is 2 cycles per instruction, with `im_ack` in the first FETCH cycle: FETCH, EXEC. With N wait cycles it is N+2.
- `code` changes only on the FETCH->EXEC edge. It is stable from the start of EXEC through the following FETCH, so the decoder output stays steady.
- The PC update and the `instret` increment occur on the EXEC->FETCH edge.
- `addr_err` rises on the EXEC->HALT edge.

## Test plan

- Reset release with zero-wait memory returning 32'h3404_0001 (ori) at 0x3000:
  - `im_req` at cycle 1 with `im_addr`=0x3000.
  - `code_valid` at cycle 2.
  - `pc`=0x3004 and `instret`=1 at cycle 3.
- Wait states: hold `im_ack` low for 3 cycles.
  - `im_req` and `im_addr` stay stable for 3 cycles.
  - `code_valid` pulses once, exactly 1 cycle.
- beq at 0x3010 with imm 16'hFFFC:
  - With `Zero`=1: next `pc`=0x3004.
  - With `Zero`=0: next `pc`=0x3014.
- jal 32'h0C00_0C10 at 0x3020 with `jsome`=1: `pc_plus4`=0x3024 during EXEC, then next `pc`=0x0000_3040.
- jr with `jr_target`=0x3100 gives next `pc`=0x3100. A following jr with `jr_target`=0x3102 gives:
  - `addr_err`=1 and HALT.
  - `im_req` stays 0 and `pc` stays 0x3100 for 10 cycles.
  - `rst` clears the block back to 0x3000.
- Assert `rst` mid-FETCH with `im_ack`=1 in the same cycle: `code` stays 0, `instret` stays 0, and a fresh fetch of 0x3000 follows release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch and next-PC stage of the MIPS core. Holds the PC,
//   fetches one word at a time over a req/ack instruction-memory handshake,
//   presents it on `code` for one EXEC cycle, then applies the decoder's
//   branch/jump controls to pick the next PC.
//
// Ports
//   clk, rst          : clock (rising edge), async active-high reset
//   im_req/im_addr    : fetch request, address (= pc while requesting)
//   im_ack/im_rdata   : memory response, sampled only while im_req is high
//   code, code_valid  : registered instruction word, high for the EXEC cycle
//   pc, pc_plus4      : address of `code`, and its link value (pc + 4)
//   Zero, npc_sel     : ALU zero flag, beq in decode
//   jsome, jr         : j/jal in decode, jr in decode
//   jr_target         : GPR[rs] read data for jr
//   addr_err          : sticky, a misaligned jr target was taken (block halts)
//   instret           : retired-instruction count, wraps at 2^32
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] code,
   output logic        code_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        Zero,
   input  logic        npc_sel,
   input  logic        jsome,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic        addr_err,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [31:0] br_off;
   logic [31:0] npc;
   logic        jr_bad;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---------------------------------------------------------------
   // Next-state decode
   // ---------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = FETCH;
         FETCH:   if (im_ack) state_nx = EXEC;
         EXEC:    state_nx = jr_bad ? HALT : FETCH;
         HALT:    state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   // Request and valid are pure state decodes so an async reset drops
   // them in the same cycle.
   assign im_req     = (state == FETCH);
   assign code_valid = (state == EXEC);
   assign im_addr    = pc;
   assign pc_plus4   = pc + 32'd4;

   // ---------------------------------------------------------------
   // Next-PC selection: jr > j/jal > taken beq > sequential
   // ---------------------------------------------------------------
   assign br_off = {{14{code[15]}}, code[15:0], 2'b00};
   assign jr_bad = jr && (jr_target[1:0] != 2'b00);

   always_comb begin
      npc = pc_plus4;
      if (jr)                  npc = jr_target;
      else if (jsome)          npc = {pc_plus4[31:28], code[25:0], 2'b00};
      else if (npc_sel && Zero) npc = pc_plus4 + br_off;
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         code     <= '0;
         addr_err <= 1'b0;
         instret  <= '0;
      end else begin
         if (state == FETCH && im_ack)
            code <= im_rdata;
         if (state == EXEC) begin
            // A misaligned jr still retires, but the PC is left pointing
            // at the offending jr.
            instret <= instret + 32'd1;
            if (jr_bad) addr_err <= 1'b1;
            else        pc       <= npc;
         end
      end
   end

endmodule
